mvm_inst_issue: RTL and testbench

Upstream issue stage for the MVM control FSM. It accepts MVM instructions over a valid/ready handshake and buffers them in a small synchronous FIFO. It issues each instruction to ctrl as a one-cycle start pulse, holding stable operand fields, then tracks ctrl's busy to detect completion. It serialises back-to-back instructions, rejects zero-length instructions, and flags a ctrl that never goes busy.

---
 rtl/mvm_pkg.sv | 17 +
 rtl/mvm_inst_fifo.sv | 35 +++
 rtl/mvm_inst_issue.sv | 98 +++++++++
 tb/tb_mvm_inst_issue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// mvm_pkg: shared widths, instruction record and issue-FSM states for the MVM issue stage
package mvm_pkg;
  localparam int VEC_AW = 8;
  localparam int MAT_AW = 9;
  localparam int VEC_SW = VEC_AW + 1;
  localparam int MAT_SW = MAT_AW + 1;
  typedef struct packed {
    logic [VEC_AW-1:0] vec_start_addr;
    logic [VEC_SW-1:0] vec_num_words;
    logic [MAT_AW-1:0] mat_start_addr;
    logic [MAT_SW-1:0] mat_num_rows;
  } mvm_inst_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, RUN} state_t;
  function automatic logic is_zero_len(input mvm_inst_t i);
    return i.vec_num_words == '0 || i.mat_num_rows == '0;
  endfunction
endpackage

// File: rtl/mvm_inst_fifo.sv
// mvm_inst_fifo: synchronous FIFO of mvm_inst_t (push/pop in, head rdata, full/empty/count out)
module mvm_inst_fifo
  import mvm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  mvm_inst_t wdata,
  output mvm_inst_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);
  mvm_inst_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) if (push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + {{(AW-1){1'b0}}, push};
      rp <= rp + {{(AW-1){1'b0}}, pop};
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign rdata = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/mvm_inst_issue.sv
// mvm_inst_issue: buffers MVM instructions (inst_* valid/ready) and issues them to ctrl via start/operands, tracking busy -> done, idle, inst_count, sticky err_zero_len/err_timeout
module mvm_inst_issue
  import mvm_pkg::*;
#(
  parameter int VEC_ADDRW = VEC_AW,
  parameter int MAT_ADDRW = MAT_AW,
  parameter int VEC_SIZEW = VEC_ADDRW + 1,
  parameter int MAT_SIZEW = MAT_ADDRW + 1,
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_TIMEOUT = 15,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int TW = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  input  logic [VEC_ADDRW-1:0] inst_vec_start_addr,
  input  logic [VEC_SIZEW-1:0] inst_vec_num_words,
  input  logic [MAT_ADDRW-1:0] inst_mat_start_addr,
  input  logic [MAT_SIZEW-1:0] inst_mat_num_rows,
  output logic                 start,
  output logic [VEC_ADDRW-1:0] vec_start_addr,
  output logic [VEC_SIZEW-1:0] vec_num_words,
  output logic [MAT_ADDRW-1:0] mat_start_addr,
  output logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
  input  logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        inst_count,
  output logic                 idle,
  output logic                 err_zero_len,
  output logic                 err_timeout
);
  state_t state;
  mvm_inst_t head;
  logic full, empty, push, pop;
  logic [TW-1:0] tcnt;
  assign push = inst_valid && inst_ready;
  assign pop = state == IDLE && !empty && !busy;
  assign inst_ready = !full;
  assign idle = empty && state == IDLE;
  mvm_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata({inst_vec_start_addr, inst_vec_num_words, inst_mat_start_addr, inst_mat_num_rows}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(inst_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      start <= 1'b0;
      done <= 1'b0;
      err_zero_len <= 1'b0;
      err_timeout <= 1'b0;
      vec_start_addr <= '0;
      vec_num_words <= '0;
      mat_start_addr <= '0;
      mat_num_rows_per_olane <= '0;
    end else begin
      start <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          vec_start_addr <= head.vec_start_addr;
          vec_num_words <= head.vec_num_words;
          mat_start_addr <= head.mat_start_addr;
          mat_num_rows_per_olane <= head.mat_num_rows;
          if (is_zero_len(head)) err_zero_len <= 1'b1;
          else begin
            state <= ISSUE;
            start <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
          tcnt <= '0;
        end
        WAIT_BUSY: if (busy) state <= RUN;
          else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            done <= 1'b1;
            state <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        RUN: if (!busy) begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mvm_inst_issue.sv
// tb_mvm_inst_issue: directed self-checking bench for mvm_inst_issue with a simple ctrl busy model
module tb_mvm_inst_issue;
  logic clk = 1'b0, rst = 1'b1;
  logic inst_valid = 1'b0, inst_ready;
  logic [7:0] inst_vec_start_addr = '0;
  logic [8:0] inst_vec_num_words = '0;
  logic [8:0] inst_mat_start_addr = '0;
  logic [9:0] inst_mat_num_rows = '0;
  logic start, busy, done, idle, err_zero_len, err_timeout;
  logic [7:0] vec_start_addr;
  logic [8:0] vec_num_words, mat_start_addr;
  logic [9:0] mat_num_rows_per_olane;
  logic [2:0] inst_count;
  int n_chk = 0, n_pass = 0, cyc = 0, bad_busy = 0, to_cyc = -1, t, acc5, n0;
  int busy_len = 8;
  logic dead = 1'b0, dly, to_seen = 1'b0;
  int rem;
  int s_cyc[$], s_vec[$], s_wrd[$], s_mat[$], s_row[$], d_cyc[$];

  mvm_inst_issue dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_vec_start_addr(inst_vec_start_addr), .inst_vec_num_words(inst_vec_num_words),
    .inst_mat_start_addr(inst_mat_start_addr), .inst_mat_num_rows(inst_mat_num_rows),
    .start(start), .vec_start_addr(vec_start_addr), .vec_num_words(vec_num_words),
    .mat_start_addr(mat_start_addr), .mat_num_rows_per_olane(mat_num_rows_per_olane),
    .busy(busy), .done(done), .inst_count(inst_count), .idle(idle),
    .err_zero_len(err_zero_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ctrl model: busy rises two cycles after start and stays high busy_len cycles; dead means never busy
  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      dly <= 1'b0;
      rem <= 0;
    end else begin
      dly <= start && !dead;
      if (dly) begin
        busy <= 1'b1;
        rem <= busy_len - 1;
      end else if (busy) begin
        if (rem == 0) busy <= 1'b0;
        else rem <= rem - 1;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (start) begin
      s_cyc.push_back(cyc);
      s_vec.push_back(int'(vec_start_addr));
      s_wrd.push_back(int'(vec_num_words));
      s_mat.push_back(int'(mat_start_addr));
      s_row.push_back(int'(mat_num_rows_per_olane));
      if (busy) bad_busy++;
    end
    if (done) d_cyc.push_back(cyc);
    if (err_timeout && !to_seen) begin
      to_seen <= 1'b1;
      to_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] v, input logic [8:0] w, input logic [8:0] m, input logic [9:0] r, output int acc);
    int n = 0;
    @(negedge clk);
    inst_vec_start_addr = v;
    inst_vec_num_words = w;
    inst_mat_start_addr = m;
    inst_mat_num_rows = r;
    inst_valid = 1'b1;
    while (!inst_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!inst_ready) check("push_ready_timeout", 0, 1);
    acc = cyc;
    @(posedge clk);
    #1 inst_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (s_cyc.size() < n && k < 300) begin
      @(negedge clk);
      #1 k++;
    end
    if (s_cyc.size() < n) check("start_timeout", s_cyc.size(), n);
  endtask

  task automatic wait_dones(input int n);
    int k = 0;
    while (d_cyc.size() < n && k < 300) begin
      @(negedge clk);
      #1 k++;
    end
    if (d_cyc.size() < n) check("done_timeout", d_cyc.size(), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(idle && !busy && !start) && k < 400);
    if (k >= 400) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < 50);
    if (!busy) check("busy_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", inst_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_count", inst_count, 0);
    check("rst_start", start, 0);
    check("rst_done", done, 0);
    check("rst_ezl", err_zero_len, 0);
    check("rst_eto", err_timeout, 0);
    check("rst_ops", {vec_start_addr, vec_num_words, mat_start_addr, mat_num_rows_per_olane}, 0);
    rst = 1'b0;

    push(8'h10, 9'd4, 9'h020, 10'd2, t);
    wait_starts(1);
    check("t1_start_cyc", s_cyc[0], t + 2);
    check("t1_vec", s_vec[0], 'h10);
    check("t1_words", s_wrd[0], 4);
    check("t1_mat", s_mat[0], 'h20);
    check("t1_rows", s_row[0], 2);
    wait_dones(1);
    check("t1_done_cyc", d_cyc[0], s_cyc[0] + 11);
    wait_idle();
    check("t1_idle", idle, 1);
    check("t1_ops_held", vec_start_addr, 8'h10);

    push(8'h30, 9'd1, 9'h030, 10'd1, t);
    wait_busy();
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 9'd5, 9'h040 + 9'(i), 10'd3, t);
    check("t2_count_full", inst_count, 4);
    check("t2_ready_low", inst_ready, 0);
    push(8'h44, 9'd5, 9'h044, 10'd3, acc5);
    wait_idle();
    check("t2_nstarts", s_cyc.size(), 7);
    for (int i = 0; i < 5; i++) check("t2_order", s_vec[2 + i], 'h40 + i);
    check("t2_fifth_accept", acc5, s_cyc[2]);
    check("t2_spacing", s_cyc[3] - s_cyc[2], 12);

    n0 = s_cyc.size();
    push(8'h50, 9'd0, 9'h051, 10'd2, t);
    push(8'h60, 9'd3, 9'h061, 10'd1, t);
    wait_idle();
    check("t3_nstarts", s_cyc.size(), n0 + 1);
    check("t3_vec", s_vec[n0], 'h60);
    check("t3_ezl", err_zero_len, 1);
    check("t3_eto", err_timeout, 0);

    dead = 1'b1;
    n0 = s_cyc.size();
    push(8'h70, 9'd2, 9'h071, 10'd2, t);
    push(8'h80, 9'd2, 9'h081, 10'd2, t);
    wait_starts(n0 + 1);
    for (int k = 0; k < 40 && !to_seen; k++) begin
      @(negedge clk);
      #1;
    end
    dead = 1'b0;
    check("t4_eto", err_timeout, 1);
    check("t4_to_cyc", to_cyc, s_cyc[n0] + 16);
    check("t4_done_cyc", d_cyc[d_cyc.size() - 1], s_cyc[n0] + 16);
    wait_starts(n0 + 2);
    check("t4_next_cyc", s_cyc[n0 + 1], s_cyc[n0] + 17);
    check("t4_next_vec", s_vec[n0 + 1], 'h80);
    wait_idle();

    push(8'h90, 9'd1, 9'h090, 10'd1, t);
    wait_busy();
    for (int i = 1; i < 4; i++) push(8'h90 + 8'(i), 9'd1, 9'h090, 10'd1, t);
    check("t5_count", inst_count, 3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_count0", inst_count, 0);
    check("t5_start", start, 0);
    check("t5_idle", idle, 1);
    check("t5_errs", {err_zero_len, err_timeout}, 0);
    check("t5_ready", inst_ready, 1);
    rst = 1'b0;

    push(8'hA0, 9'd1, 9'h0A0, 10'd1, t);
    wait_busy();
    push(8'hA1, 9'd6, 9'h0A2, 10'd7, t);
    push(8'hB1, 9'd2, 9'h0B2, 10'd3, t);
    check("t6_count_pre", inst_count, 2);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 50);
      check("t6_done_seen", done, 1);
    end
    check("t6_count_at_pop", inst_count, 2);
    inst_vec_start_addr = 8'hC1;
    inst_vec_num_words = 9'd1;
    inst_mat_start_addr = 9'h0C1;
    inst_mat_num_rows = 10'd1;
    inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    check("t6_count_post", inst_count, 2);
    check("t6_pop_vec", vec_start_addr, 8'hA1);
    check("t6_pop_words", vec_num_words, 9'd6);
    check("t6_pop_mat", mat_start_addr, 9'h0A2);
    check("t6_pop_rows", mat_num_rows_per_olane, 10'd7);
    wait_idle();
    check("no_start_while_busy", bad_busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
